// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One op in flight: accept in IDLE, sample the ALU in EXEC, hold the result in RESP.
module alu_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_func,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_func,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [1:0]   alu_func,
  output logic [W-1:0] alu_src1,
  output logic [W-1:0] alu_src2,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  input  logic         rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic         id;
    logic [1:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  state_e       state_q, state_d;
  op_t          op_q, op_d;
  logic         last_grant_q, last_grant_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;

  logic gnt_vld;
  logic gnt_idx;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_idx = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && gnt_vld) begin
          req0_ready   = ~gnt_idx;
          req1_ready   = gnt_idx;
          op_d         = gnt_idx ? {1'b1, req1_func, req1_a, req1_b}
                                 : {1'b0, req0_func, req0_a, req0_b};
          last_grant_d = gnt_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = op_q.id;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  // ALU operands come straight from the latched op so they stay put until the next accept.
  assign alu_func   = op_q.func;
  assign alu_src1   = op_q.a;
  assign alu_src2   = op_q.b;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle-count reference model predicts grants
// and results, a separate monitor pops expectations on every response handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_func, req1_func, alu_func;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_src1, alu_src2, alu_result, rsp_result;
  logic        rsp_valid, rsp_id, rsp_ready;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_func(alu_func), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready)
  );

  function automatic logic [15:0] alu_ref(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (a < b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_func, alu_src1, alu_src2);

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] res;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: idle -> grant rule; accepted op owes a response two cycles later,
  // then the slot stays busy until that response is taken.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  logic [1:0]  m_f;
  logic [15:0] m_a, m_b;

  initial forever begin : model
    int   g;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("rdy_in_rst", {req1_ready, req0_ready}, 2'b00);
      m_busy = 0; m_age = 0; m_last = 1;
      exp_q.delete();
    end else if (!m_busy) begin
      g = -1;
      if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      chk("grant", {req1_ready, req0_ready}, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
      chk("idle_rsp_valid", rsp_valid, 1'b0);
      if (g >= 0) begin
        m_f = (g == 1) ? req1_func : req0_func;
        m_a = (g == 1) ? req1_a    : req0_a;
        m_b = (g == 1) ? req1_b    : req0_b;
        e.id  = (g == 1);
        e.res = alu_ref(m_f, m_a, m_b);
        exp_q.push_back(e);
        m_last = (g == 1);
        m_busy = 1; m_age = 0;
      end
    end else begin
      m_age++;
      chk("busy_rdy", {req1_ready, req0_ready}, 2'b00);
      if (m_age == 1) begin
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("alu_ops", {alu_func, alu_src1, alu_src2}, {m_f, m_a, m_b});
      end else begin
        chk("resp_valid", rsp_valid, 1'b1);
        if (rsp_ready) m_busy = 0;
      end
    end
  end

  bit          stall;
  logic        s_id;
  logic [15:0] s_res;

  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid",  rsp_valid,  1'b1);
        chk("hold_id",     rsp_id,     s_id);
        chk("hold_result", rsp_result, s_res);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_rsp: got id %0d result %0h expected no response", rsp_id, rsp_result);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
        end
      end
      stall = rsp_valid && !rsp_ready;
      s_id  = rsp_id;
      s_res = rsp_result;
    end
  end

  task automatic drive(input int n, input logic [1:0] f, input logic [15:0] a, input logic [15:0] b, input logic v);
    if (n == 0) begin req0_func = f; req0_a = a; req0_b = b; req0_valid = v; end
    else        begin req1_func = f; req1_a = a; req1_b = b; req1_valid = v; end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input int n);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (n == 1) ? req1_ready : req0_ready;
    end
    chk("accept_timeout", got, 1'b1);
  endtask

  // Issue one op, then check the response arrives exactly two cycles after acceptance.
  task automatic issue_chk(input int n, input logic [1:0] f, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    drive(n, f, a, b, 1'b1);
    wait_accept(n);
    next_cycle();
    drive(n, f, a, b, 1'b0);
    @(negedge clk);
    chk("lat_early", rsp_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", rsp_valid, 1'b1);
    chk("dir_id", rsp_id, (n == 1));
    chk("dir_result", rsp_result, exp);
    next_cycle();
  endtask

  initial begin : main
    int order[$];
    rst = 1'b1; rsp_ready = 1'b1;
    drive(0, 2'd0, 16'd0, 16'd0, 1'b0);
    drive(1, 2'd0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid",  rsp_valid,  1'b0);
    chk("rst_rsp_id",     rsp_id,     1'b0);
    chk("rst_rsp_result", rsp_result, 16'h0);
    chk("rst_alu", {alu_func, alu_src1, alu_src2}, 34'h0);
    next_cycle();
    rst = 1'b0;

    issue_chk(0, 2'd0, 16'h0003, 16'h0004, 16'h0007);
    issue_chk(1, 2'd1, 16'h0002, 16'h0005, 16'hFFFD);
    issue_chk(1, 2'd2, 16'h0100, 16'h0100, 16'h0000);
    issue_chk(0, 2'd3, 16'hFFFF, 16'h0001, 16'h0000);
    issue_chk(0, 2'd3, 16'h0001, 16'hFFFF, 16'h0001);

    // Contention straight after reset: grants must alternate starting with requester 0.
    rst = 1'b1; next_cycle(); rst = 1'b0;
    drive(0, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (req0_ready) order.push_back(0);
      if (req1_ready) order.push_back(1);
      next_cycle();
      drive(0, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) next_cycle();
    chk("cont_count", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("cont_order", order[i], i % 2);

    // Backpressure: five stalled RESP cycles, then the waiting requester goes next cycle.
    rsp_ready = 1'b0;
    drive(0, 2'd2, 16'h1234, 16'h0010, 1'b1);
    wait_accept(0);
    next_cycle();
    req0_valid = 1'b0;
    drive(1, 2'd1, 16'h0100, 16'h0001, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdy", {req1_ready, req0_ready}, 2'b00);
    end
    next_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake", rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp_accept", req1_ready, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    repeat (3) next_cycle();

    // Reset during EXEC discards the op and restores requester-0 priority.
    drive(0, 2'd0, 16'hABCD, 16'h1111, 1'b1);
    wait_accept(0);
    next_cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 2'd1, 16'h0009, 16'h0003, 1'b1);
    drive(1, 2'd0, 16'h0005, 16'h0006, 1'b1);
    @(negedge clk);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_alu", {alu_func, alu_src1, alu_src2}, 34'h0);
    chk("mid_rst_grant", {req1_ready, req0_ready}, 2'b01);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) next_cycle();

    // Idle hold leaves last_grant at 0, so the next contention goes to requester 1.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hold", {rsp_valid, req1_ready, req0_ready}, 3'b000);
    end
    next_cycle();
    drive(0, 2'd0, 16'h0001, 16'h0001, 1'b1);
    drive(1, 2'd3, 16'h0002, 16'h0003, 1'b1);
    @(negedge clk);
    chk("idle_then_grant", {req1_ready, req0_ready}, 2'b10);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) next_cycle();

    for (int c = 0; c < 400; c++) begin
      drive(0, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) next_cycle();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
